// File: rtl/if_stage_ctrl_pkg.sv
// Shared fetch-stage definitions: sequencer states, bubble encoding and PC step.
// The decode and hazard units use NOP_INSTR for bubble insertion as well.
package if_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return |addr[1:0];
   endfunction

endpackage

// File: rtl/if_stage_ctrl_if.sv
// Instruction memory bus between the fetch sequencer and a zero-latency IMEM.
interface if_stage_ctrl_if #(
   parameter int IMEM_AW = 9
);
   logic [IMEM_AW-1:0] imem_addr_o;
   logic [31:0]        imem_instr_i;

   modport master (output imem_addr_o, input  imem_instr_i);
   modport slave  (input  imem_addr_o, output imem_instr_i);
endinterface

// File: rtl/if_stage_ctrl_pc_reg.sv
// Program counter register with load enable and asynchronous clear.
module pc_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] in,
   output logic [W-1:0] out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= '0;
      else if (en)
         out <= in;
   end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives IMEM, loads and squashes IF/ID.
// Priority in S_RUN is redirect > stall > sequential fetch.
module if_stage_ctrl #(
   parameter int          IMEM_AW   = 9,
   parameter logic [31:0] NOP_INSTR = if_stage_ctrl_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   if_stage_ctrl_if.master   imem,
   output logic [31:0]       pc_o,
   output logic [31:0]       ifid_pc_o,
   output logic [31:0]       ifid_instr_o,
   output logic              ifid_valid_o,
   output logic              fault_o,
   output logic [31:0]       fetch_cnt_o
);
   import if_stage_ctrl_pkg::*;

   state_t      state, state_nxt;
   logic        misaligned;
   logic        pc_en;
   logic [31:0] pc_in;
   logic [31:0] ifid_pc_nxt, ifid_instr_nxt, fetch_cnt_nxt;
   logic        ifid_valid_nxt, fault_nxt;

   assign misaligned = redirect_i & is_misaligned(redirect_pc_i);
   assign pc_en      = (state == S_RUN) & (redirect_i | ~stall_i) & ~misaligned;
   assign pc_in      = redirect_i ? redirect_pc_i : pc_o + PC_STEP;

   pc_reg #(.W(32)) u_pc_reg (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .in  (pc_in),
      .out (pc_o)
   );

   assign imem.imem_addr_o = pc_o[IMEM_AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_BOOT;
         ifid_pc_o    <= '0;
         ifid_instr_o <= NOP_INSTR;
         ifid_valid_o <= 1'b0;
         fault_o      <= 1'b0;
         fetch_cnt_o  <= '0;
      end else begin
         state        <= state_nxt;
         ifid_pc_o    <= ifid_pc_nxt;
         ifid_instr_o <= ifid_instr_nxt;
         ifid_valid_o <= ifid_valid_nxt;
         fault_o      <= fault_nxt;
         fetch_cnt_o  <= fetch_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      ifid_pc_nxt    = ifid_pc_o;
      ifid_instr_nxt = ifid_instr_o;
      ifid_valid_nxt = ifid_valid_o;
      fault_nxt      = fault_o;
      fetch_cnt_nxt  = fetch_cnt_o;
      case (state)
         S_BOOT: state_nxt = S_RUN;
         S_RUN: begin
            if (redirect_i) begin
               // Squash the wrong-path fetch; a bad target parks the stage in S_FAULT.
               ifid_valid_nxt = 1'b0;
               ifid_instr_nxt = NOP_INSTR;
               if (misaligned) begin
                  fault_nxt = 1'b1;
                  state_nxt = S_FAULT;
               end else begin
                  ifid_pc_nxt = '0;
               end
            end else if (!stall_i) begin
               ifid_pc_nxt    = pc_o;
               ifid_instr_nxt = imem.imem_instr_i;
               ifid_valid_nxt = 1'b1;
               fetch_cnt_nxt  = fetch_cnt_o + 32'd1;
            end
         end
         S_FAULT: begin
            ifid_valid_nxt = 1'b0;
            fault_nxt      = 1'b1;
         end
         default: state_nxt = S_BOOT;
      endcase
   end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl with a zero-latency instruction memory model.
module tb_if_stage_ctrl;

   localparam int          AW  = 9;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] pc_o, ifid_pc_o, ifid_instr_o, fetch_cnt_o;
   logic        ifid_valid_o, fault_o;

   logic [31:0] mem [128];
   int          n_checks = 0;
   int          n_errors = 0;

   if_stage_ctrl_if #(.IMEM_AW(AW)) imem ();

   assign imem.imem_instr_i = mem[imem.imem_addr_o[AW-1:2]];

   if_stage_ctrl #(.IMEM_AW(AW), .NOP_INSTR(NOP)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem          (imem),
      .pc_o          (pc_o),
      .ifid_pc_o     (ifid_pc_o),
      .ifid_instr_o  (ifid_instr_o),
      .ifid_valid_o  (ifid_valid_o),
      .fault_o       (fault_o),
      .fetch_cnt_o   (fetch_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic [31:0] instr, input logic vld, input logic [31:0] cnt);
      check({tag, ".pc"}, pc_o, pc);
      check({tag, ".ifid_pc"}, ifid_pc_o, ipc);
      check({tag, ".ifid_instr"}, ifid_instr_o, instr);
      check({tag, ".ifid_valid"}, {31'd0, ifid_valid_o}, {31'd0, vld});
      check({tag, ".fetch_cnt"}, fetch_cnt_o, cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = {16'hA5A5, 16'(i)};
      mem[0] = 32'h00500093;
      mem[1] = 32'h00A00113;
      mem[2] = 32'h002081B3;
      mem[3] = 32'h00000013;

      // Reset state
      @(negedge clk);
      chk_ifid("rst", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
      check("rst.fault", {31'd0, fault_o}, 32'd0);
      check("rst.imem_addr", {23'd0, imem.imem_addr_o}, 32'h0);
      rst = 1'b0;

      // Boot cycle then four sequential fetches
      step();
      chk_ifid("boot", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
      step(); chk_ifid("seq0", 32'h4,  32'h0, 32'h00500093, 1'b1, 32'd1);
      step(); chk_ifid("seq1", 32'h8,  32'h4, 32'h00A00113, 1'b1, 32'd2);
      step(); chk_ifid("seq2", 32'hC,  32'h8, 32'h002081B3, 1'b1, 32'd3);
      step(); chk_ifid("seq3", 32'h10, 32'hC, 32'h00000013, 1'b1, 32'd4);

      // Stall at pc=8 for three cycles
      do_reset();
      step(); step(); step();
      chk_ifid("pre_stall", 32'h8, 32'h4, 32'h00A00113, 1'b1, 32'd2);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("stall", 32'h8, 32'h4, 32'h00A00113, 1'b1, 32'd2);
      end
      stall_i = 1'b0;
      step(); chk_ifid("unstall", 32'hC, 32'h8, 32'h002081B3, 1'b1, 32'd3);

      // Redirect at pc=C to 0x40: one bubble, then the target fetch
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      step(); chk_ifid("redir", 32'h40, 32'h0, NOP, 1'b0, 32'd3);
      redirect_i = 1'b0;
      step(); chk_ifid("redir_tgt", 32'h44, 32'h40, 32'hA5A50010, 1'b1, 32'd4);

      // Redirect together with stall: redirect wins
      redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h20;
      step(); chk_ifid("redir_stall", 32'h20, 32'h0, NOP, 1'b0, 32'd4);
      redirect_i = 1'b0; stall_i = 1'b0;
      step(); chk_ifid("redir_stall_tgt", 32'h24, 32'h20, 32'hA5A50008, 1'b1, 32'd5);

      // Address wrap at the top of IMEM
      redirect_i = 1'b1; redirect_pc_i = 32'h1FC;
      step();
      check("wrap0.imem_addr", {23'd0, imem.imem_addr_o}, 32'h1FC);
      redirect_i = 1'b0;
      step();
      chk_ifid("wrap1", 32'h200, 32'h1FC, 32'hA5A5007F, 1'b1, 32'd6);
      check("wrap1.imem_addr", {23'd0, imem.imem_addr_o}, 32'h000);
      step();
      chk_ifid("wrap2", 32'h204, 32'h200, 32'h00500093, 1'b1, 32'd7);
      check("wrap2.fault", {31'd0, fault_o}, 32'd0);

      // Asynchronous reset between edges while stalled
      stall_i = 1'b1;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_ifid("async_rst", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
      check("async_rst.imem_addr", {23'd0, imem.imem_addr_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0; stall_i = 1'b0;

      // Misaligned redirect: sticky fault, everything frozen
      step(); step(); step();
      chk_ifid("pre_fault", 32'h8, 32'h4, 32'h00A00113, 1'b1, 32'd2);
      redirect_i = 1'b1; redirect_pc_i = 32'h22;
      step();
      chk_ifid("fault", 32'h8, 32'h4, NOP, 1'b0, 32'd2);
      check("fault.flag", {31'd0, fault_o}, 32'd1);
      redirect_pc_i = 32'h40;
      for (int i = 0; i < 5; i++) begin
         redirect_i = i[0];
         stall_i    = i[1];
         step();
         check("fault_hold.pc", pc_o, 32'h8);
         check("fault_hold.valid", {31'd0, ifid_valid_o}, 32'd0);
         check("fault_hold.flag", {31'd0, fault_o}, 32'd1);
         check("fault_hold.cnt", fetch_cnt_o, 32'd2);
      end
      redirect_i = 1'b0; stall_i = 1'b0;
      rst = 1'b1;
      #1;
      check("fault_rst.flag", {31'd0, fault_o}, 32'd0);
      check("fault_rst.pc", pc_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("fault_rst.boot_valid", {31'd0, ifid_valid_o}, 32'd0);
      step();
      chk_ifid("fault_rst.run", 32'h4, 32'h0, 32'h00500093, 1'b1, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
Fetch-stage sequencer for the pipelined RISC-V core. It owns the PC, drives the instruction memory address, and selects the next PC from sequential, stall and redirect sources. It also loads the IF/ID pipeline register and squashes fetched instructions on branches/jumps. It sits between the PC register / instruction memory pair and the decode stage, and takes stall and redirect commands from the hazard unit and EX stage.

Parameters:
IMEM_AW, 9, instruction memory byte-address width; imem_addr_o = pc[IMEM_AW-1:0]
NOP_INSTR, 32'h00000013, encoding (addi x0,x0,0) loaded into IF/ID on bubbles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
stall_i  input  1  load-use hazard: hold PC and IF/ID
redirect_i  input  1  taken branch/jump resolved in EX
redirect_pc_i  input  32  redirect target byte address
imem_addr_o  output  IMEM_AW  instruction memory address
imem_instr_i  input  32  combinational instruction memory read data
pc_o  output  32  current fetch PC
ifid_pc_o  output  32  PC of instruction in IF/ID
ifid_instr_o  output  32  instruction in IF/ID
ifid_valid_o  output  1  IF/ID holds a real instruction
fault_o  output  1  misaligned redirect target seen; sticky
fetch_cnt_o  output  32  count of valid instructions delivered to IF/ID

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high. All state is cleared immediately on rst=1, regardless of clk.
- Reset values:
  - pc_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0
  - fault_o=0, fetch_cnt_o=0, state=S_BOOT
- imem_addr_o = pc_o[IMEM_AW-1:0] combinationally. Memory read is zero-latency, so instruction and PC reach IF/ID on the same edge.
- States: S_BOOT, S_RUN, S_FAULT.
- S_BOOT (first edge after rst deasserts):
  - pc holds 0, ifid_valid_o stays 0; go to S_RUN.
  - Inputs are ignored in this state.
- S_RUN, evaluated per edge with priority redirect > stall > sequential:
  - redirect_i=1, redirect_pc_i[1:0]!=0:
    - pc holds; ifid_valid_o<=0; ifid_instr_o<=NOP_INSTR
    - fault_o<=1; go to S_FAULT
  - redirect_i=1, target aligned:
    - pc<=redirect_pc_i
    - ifid_valid_o<=0, ifid_instr_o<=NOP_INSTR, ifid_pc_o<=0. This squashes the wrong-path fetch; redirect costs exactly 1 bubble.
    - redirect with stall_i=1 also takes this branch: redirect wins and the stall is dropped.
  - stall_i=1 (no redirect): pc, ifid_pc_o, ifid_instr_o, ifid_valid_o and fetch_cnt_o all hold.
  - Otherwise:
    - ifid_pc_o<=pc, ifid_instr_o<=imem_instr_i, ifid_valid_o<=1
    - pc<=pc+4, mod 2^32. imem_addr_o therefore wraps modulo 2^IMEM_AW; no error is raised.
    - fetch_cnt_o<=fetch_cnt_o+1, wrapping at 2^32.
- S_FAULT:
  - pc and fetch_cnt_o frozen; ifid_valid_o=0; fault_o=1.
  - All inputs ignored; the only exit is rst.
- A reset asserted mid-stall or mid-redirect returns everything to reset values asynchronously, then S_BOOT.
- pc is always word-aligned: pc[1:0]==0 invariant.

Decomposition:
- Shared package:
  - state enum {S_BOOT, S_RUN, S_FAULT}
  - NOP_INSTR constant, shared with the decode/hazard units for bubble insertion
  - PC_STEP=4
- Sub-module: reuse pc_reg (clk, rst, en, in, out) for the PC.
  - en = (state==S_RUN) & (redirect_i | ~stall_i) & ~misaligned
  - in = redirect_i ? redirect_pc_i : pc+4
- The IF/ID register, counter and FSM live in if_stage_ctrl.

Test Plan:
- Reset then 4 free-running cycles, memory holding 00500093, 00A00113, 002081B3, 00000013:
  - boot cycle has ifid_valid_o=0
  - then ifid_pc_o = 0, 4, 8, C with matching instructions
  - pc_o=10, fetch_cnt_o=4
- stall_i=1 for 3 cycles at pc=8 -> pc_o, ifid_* and fetch_cnt_o unchanged for all 3 cycles; on release, ifid_pc_o=8 on the next edge.
- redirect_i=1, redirect_pc_i=40 at pc=C:
  - next edge: pc_o=40, ifid_valid_o=0, ifid_instr_o=00000013
  - following edge: ifid_pc_o=40, ifid_valid_o=1
- redirect_i=1 and stall_i=1 together, target 20 -> pc_o=20, bubble in IF/ID (redirect wins).
- redirect_pc_i=22 -> fault_o=1, ifid_valid_o=0. pc_o stays frozen across 5 further cycles of stall/redirect toggling; rst clears fault_o=0, pc_o=0.
- Wrap: redirect to 1FC, run 2 cycles -> imem_addr_o goes 1FC then 000 while pc_o=200. Also assert rst asynchronously between edges mid-run -> outputs reach reset values before the next clk edge.
